// File: rtl/hex_display_bank_pkg.sv
// Shared constants for the multi-digit hex display: glyph table, segment indices, dark pattern.
package hex_display_bank_pkg;

    localparam int unsigned NIB_W = 4;

    localparam int unsigned SEG_A = 0;
    localparam int unsigned SEG_B = 1;
    localparam int unsigned SEG_C = 2;
    localparam int unsigned SEG_D = 3;
    localparam int unsigned SEG_E = 4;
    localparam int unsigned SEG_F = 5;
    localparam int unsigned SEG_G = 6;
    localparam int unsigned SEG_W = SEG_G - SEG_A + 1;

    // Active-high "all segments off"; board polarity is applied by the top.
    localparam logic [SEG_W-1:0] SEG_DARK = 7'h00;

    // Active-high a..g encodings (bit0 = a) for hex digits 0-F.
    localparam logic [SEG_W-1:0] GLYPH [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

endpackage

// File: rtl/hex_display_bank_glyph.sv
// Combinational 4-bit to active-high 7-segment glyph decoder.
module hex_glyph
    import hex_display_bank_pkg::*;
(
    input  logic [NIB_W-1:0] i_digit,
    output logic [SEG_G:SEG_A] o_seg
);

    assign o_seg = GLYPH[i_digit];

endmodule

// File: rtl/hex_display_bank.sv
// Multi-digit hex display driver: latched value, leading-zero suppression,
// per-digit blink from an internal divider, and registered segment outputs.
module hex_display_bank
    import hex_display_bank_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned BLINK_DIV      = 25000000,
    parameter bit          SEG_ACTIVE_LOW = 1'b1
) (
    input  logic                          CLOCK_50,
    input  logic                          resetn,
    input  logic [NIB_W*NUM_DIGITS-1:0]   value,
    input  logic                          load,
    input  logic                          lz_suppress,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    input  logic                          blank_all,
    output logic [SEG_W*NUM_DIGITS-1:0]   HEX,
    output logic                          blink_phase
);

    localparam int unsigned VAL_W    = NIB_W * NUM_DIGITS;
    localparam int unsigned HEX_W    = SEG_W * NUM_DIGITS;
    localparam int unsigned CNT_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_DIV - 1);
    localparam logic [SEG_W-1:0] SEG_OFF  = SEG_ACTIVE_LOW ? ~SEG_DARK : SEG_DARK;

    logic [VAL_W-1:0]      r_value;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_phase;
    logic [HEX_W-1:0]      r_hex;
    logic [HEX_W-1:0]      w_glyph;
    logic [HEX_W-1:0]      w_hex;
    logic [NUM_DIGITS-1:0] w_lz;

    for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
        hex_glyph u_glyph (
            .i_digit (r_value[NIB_W*g +: NIB_W]),
            .o_seg   (w_glyph[SEG_W*g +: SEG_W])
        );
    end

    // A digit is a leading zero when it and every digit above it are zero; digit 0 always shows.
    always_comb begin : lz_scan
        logic w_run;
        w_lz  = '0;
        w_run = 1'b1;
        for (int i = int'(NUM_DIGITS) - 1; i >= 0; i--) begin
            w_run = w_run & (r_value[NIB_W*i +: NIB_W] == '0);
            if (i != 0) begin
                w_lz[i] = w_run & lz_suppress;
            end
        end
    end

    always_comb begin : seg_compose
        logic [SEG_W-1:0] w_seg;
        w_hex = '0;
        w_seg = SEG_DARK;
        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            w_seg = w_glyph[SEG_W*i +: SEG_W];
            if (blank_all || (blink_mask[i] && r_phase) || w_lz[i]) begin
                w_seg = SEG_DARK;
            end
            w_hex[SEG_W*i +: SEG_W] = SEG_ACTIVE_LOW ? ~w_seg : w_seg;
        end
    end

    always_ff @(posedge CLOCK_50) begin
        if (!resetn) begin
            r_value <= '0;
            r_cnt   <= '0;
            r_phase <= 1'b0;
            r_hex   <= {NUM_DIGITS{SEG_OFF}};
        end else begin
            if (load) begin
                r_value <= value;
            end
            if (r_cnt == CNT_LAST) begin
                r_cnt   <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
            r_hex <= w_hex;
        end
    end

    assign HEX         = r_hex;
    assign blink_phase = r_phase;

endmodule

// File: tb/tb_hex_display_bank.sv
// Scoreboard bench: stimulus queues expected HEX/phase per cycle, a negedge monitor compares.
module tb_hex_display_bank;

    localparam logic [6:0] DK = 7'h7F;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic [15:0] value;
    logic        load, lz, blank;
    logic [3:0]  bmask;
    logic [27:0] hex;
    logic        phase;

    logic [3:0]  value1;
    logic        load1, lz1, blank1;
    logic [0:0]  bmask1;
    logic [6:0]  hex1;
    logic        phase1;

    hex_display_bank #(.NUM_DIGITS(4), .BLINK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut (
        .CLOCK_50(clk), .resetn(resetn), .value(value), .load(load),
        .lz_suppress(lz), .blink_mask(bmask), .blank_all(blank),
        .HEX(hex), .blink_phase(phase)
    );

    hex_display_bank #(.NUM_DIGITS(1), .BLINK_DIV(4), .SEG_ACTIVE_LOW(1'b1)) dut1 (
        .CLOCK_50(clk), .resetn(resetn), .value(value1), .load(load1),
        .lz_suppress(lz1), .blink_mask(bmask1), .blank_all(blank1),
        .HEX(hex1), .blink_phase(phase1)
    );

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;
    int next_id = 0;

    typedef struct {
        int          due;
        int          id;
        bit          wide;
        logic [27:0] hex;
        bit          chk_ph;
        bit          ph;
    } exp_t;

    exp_t sb[$];

    logic [6:0] glyph_tab [16] = '{
        7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
        7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
    };

    function automatic logic [6:0] on(input logic [3:0] d);
        return ~glyph_tab[d];
    endfunction

    task automatic push4(input int dly, input logic [27:0] h, input bit cp, input bit p);
        exp_t e;
        e.due = cyc + dly; e.id = next_id; e.wide = 1'b1;
        e.hex = h; e.chk_ph = cp; e.ph = p;
        next_id++;
        sb.push_back(e);
    endtask

    task automatic push1(input int dly, input logic [6:0] h);
        exp_t e;
        e.due = cyc + dly; e.id = next_id; e.wide = 1'b0;
        e.hex = {21'b0, h}; e.chk_ph = 1'b0; e.ph = 1'b0;
        next_id++;
        sb.push_back(e);
    endtask

    always @(negedge clk) begin : monitor
        int i;
        logic [27:0] act;
        i = 0;
        while (i < sb.size()) begin
            if (sb[i].due == cyc) begin
                act = sb[i].wide ? hex : {21'b0, hex1};
                checks++;
                if (act !== sb[i].hex) begin
                    errors++;
                    $display("FAIL hex id=%0d wide=%0d cyc=%0d got=%h want=%h",
                             sb[i].id, sb[i].wide, cyc, act, sb[i].hex);
                end
                if (sb[i].chk_ph) begin
                    checks++;
                    if (phase !== sb[i].ph) begin
                        errors++;
                        $display("FAIL blink_phase id=%0d cyc=%0d got=%b want=%b",
                                 sb[i].id, cyc, phase, sb[i].ph);
                    end
                end
                sb.delete(i);
            end else begin
                i++;
            end
        end
    end

    initial begin
        resetn = 1'b0; load = 1'b1; value = 16'h1234; lz = 1'b0; blank = 1'b0; bmask = 4'b0;
        load1 = 1'b1; value1 = 4'h8; lz1 = 1'b0; blank1 = 1'b0; bmask1 = 1'b0;

        // Reset dominates load; all segments dark, phase 0.
        for (int k = 1; k <= 3; k++) begin
            push4(k, {4{DK}}, 1'b1, 1'b0);
            push1(k, DK);
        end
        repeat (3) @(negedge clk);

        // Released: register still 0 until a load.
        resetn = 1'b1; load = 1'b0; load1 = 1'b0;
        push4(1, {4{on(4'h0)}}, 1'b0, 1'b0);
        push4(2, {4{on(4'h0)}}, 1'b0, 1'b0);
        @(negedge clk);

        load = 1'b1; value = 16'hBEEF;
        push4(2, {on(4'hB), on(4'hE), on(4'hE), on(4'hF)}, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0; value = 16'h1234;
        push4(2, {on(4'hB), on(4'hE), on(4'hE), on(4'hF)}, 1'b0, 1'b0);
        @(negedge clk);

        // Single-digit glyph sweep, suppression enabled but without effect.
        lz1 = 1'b1;
        for (int d = 0; d < 16; d++) begin
            load1 = 1'b1; value1 = 4'(d);
            push1(2, on(4'(d)));
            @(negedge clk);
        end
        load1 = 1'b0; value1 = 4'h3;
        push1(2, on(4'hF));
        @(negedge clk);

        // Leading-zero suppression.
        lz = 1'b1; load = 1'b1; value = 16'h0050;
        push4(2, {DK, DK, on(4'h5), on(4'h0)}, 1'b0, 1'b0);
        @(negedge clk);
        value = 16'h0000;
        push4(2, {DK, DK, DK, on(4'h0)}, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        lz = 1'b0;
        push4(1, {4{on(4'h0)}}, 1'b0, 1'b0);
        @(negedge clk);

        // blank_all overrides blink and suppression, then the display returns.
        lz = 1'b1; load = 1'b1; value = 16'h0050; bmask = 4'b1100;
        push4(2, {DK, DK, on(4'h5), on(4'h0)}, 1'b0, 1'b0);
        @(negedge clk);
        load = 1'b0;
        @(negedge clk);
        blank = 1'b1;
        push4(1, {4{DK}}, 1'b0, 1'b0);
        @(negedge clk);
        blank = 1'b0;
        push4(1, {DK, DK, on(4'h5), on(4'h0)}, 1'b0, 1'b0);
        @(negedge clk);
        bmask = 4'b0; lz = 1'b0;

        // Reset while the divider is running, then blink digit 0.
        resetn = 1'b0;
        push4(1, {4{DK}}, 1'b1, 1'b0);
        push1(1, DK);
        @(negedge clk);
        resetn = 1'b1; load = 1'b1; value = 16'h1111; bmask = 4'b0001;
        for (int k = 2; k <= 13; k++) begin
            push4(k, {on(4'h1), on(4'h1), on(4'h1), (((k - 1) / 4) % 2 == 1) ? DK : on(4'h1)},
                  1'b1, ((k / 4) % 2) == 1);
        end
        @(negedge clk);
        load = 1'b0;
        repeat (14) @(negedge clk);

        for (int w = 0; w < 20 && sb.size() != 0; w++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            $display("FAIL pending checks never matured: %0d left", sb.size());
            checks += sb.size();
            errors += sb.size();
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
